ulpi_phy_emu: RTL and testbench

PHY-side ULPI responder: the counterpart of the ULPI link in `top`, modelling a USB3300-class PHY on the 60 MHz ULPI clock. It drives DIR/NXT/DATA and answers link register writes, reads and transmit commands. It generates the reset sequence and RXCMDs on line-state changes. It is synthesizable, so it can back a loopback board build as well as the system bench.

---
 rtl/ulpi_phy_emu_if.sv | 20 ++
 rtl/ulpi_phy_emu.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ulpi_phy_emu.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_phy_emu_if.sv
// rtl/ulpi_phy_emu_if.sv - ULPI bus between the link (master) and the PHY emulator (slave)
interface ulpi_phy_emu_if;
  logic       ULPI_RESETN;
  logic       ULPI_STP;
  logic [7:0] ULPI_DATA_IN;
  logic [7:0] ULPI_DATA_OUT;
  logic       ULPI_DATA_OE;
  logic       ULPI_DIR;
  logic       ULPI_NXT;

  modport master (
    output ULPI_RESETN, ULPI_STP, ULPI_DATA_IN,
    input  ULPI_DATA_OUT, ULPI_DATA_OE, ULPI_DIR, ULPI_NXT
  );

  modport slave (
    input  ULPI_RESETN, ULPI_STP, ULPI_DATA_IN,
    output ULPI_DATA_OUT, ULPI_DATA_OE, ULPI_DIR, ULPI_NXT
  );
endinterface

// File: rtl/ulpi_phy_emu.sv
// rtl/ulpi_phy_emu.sv - PHY-side ULPI responder
// One FSM whose bus outputs are registered from the next-state decode.
module ulpi_phy_emu #(
  parameter int RESET_DIR_CYCLES = 4,
  parameter int POST_RESET_IDLE  = 4,
  parameter int STP_TIMEOUT      = 16
) (
  input  logic          CLK,
  input  logic          RST,
  ulpi_phy_emu_if.slave ulpi,
  input  logic [1:0]    LINESTATE,
  input  logic [1:0]    VBUS,
  output logic [7:0]    FUNC_CTRL,
  output logic [7:0]    OTG_CTRL,
  output logic [3:0]    TX_PID,
  output logic [15:0]   TX_BYTE_CNT,
  output logic          TX_DONE,
  output logic          ERR
);
  typedef enum logic [3:0] {
    S_RESET_HOLD, S_POST_IDLE, S_RX_TURN, S_RX_DATA, S_IDLE,
    S_WR_ACKCMD, S_WR_ACKDATA, S_WR_WAITSTP,
    S_RD_ACKCMD, S_RD_TURN, S_RD_DATA, S_TX_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  pid_q, pid_d;
  logic [15:0] bytes_q, bytes_d;
  logic [7:0]  func_q, func_d, ifc_q, ifc_d, otg_q, otg_d, scratch_q, scratch_d;
  logic [7:0]  last_rxcmd_q, last_rxcmd_d;
  logic        dir_q, dir_d, nxt_q, nxt_d, oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic [3:0]  tx_pid_q, tx_pid_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        tx_done_q, tx_done_d, err_q, err_d;
  logic [7:0]  rxcmd, rd_val;

  assign rxcmd = {4'b0000, VBUS, LINESTATE};

  // op 0 = write, 1 = set, 2 = clear
  function automatic logic [7:0] wr_apply(input logic [7:0] cur, input logic [5:0] op,
                                          input logic [7:0] d);
    case (op)
      6'd0:    wr_apply = d;
      6'd1:    wr_apply = cur | d;
      default: wr_apply = cur & ~d;
    endcase
  endfunction

  always_comb begin
    rd_val = 8'h00;
    case (addr_q)
      6'h00:               rd_val = 8'h24;
      6'h01:               rd_val = 8'h04;
      6'h02:               rd_val = 8'h06;
      6'h04, 6'h05, 6'h06: rd_val = func_q;
      6'h07, 6'h08, 6'h09: rd_val = ifc_q;
      6'h0A, 6'h0B, 6'h0C: rd_val = otg_q;
      6'h16, 6'h17, 6'h18: rd_val = scratch_q;
      default:             rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pid_d        = pid_q;
    bytes_d      = bytes_q;
    func_d       = func_q;
    ifc_d        = ifc_q;
    otg_d        = otg_q;
    scratch_d    = scratch_q;
    last_rxcmd_d = last_rxcmd_q;
    tx_pid_d     = tx_pid_q;
    tx_cnt_d     = tx_cnt_q;
    dir_d        = 1'b0;
    nxt_d        = 1'b0;
    oe_d         = 1'b0;
    dout_d       = 8'h00;
    tx_done_d    = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_RESET_HOLD: begin
        dir_d = 1'b1;
        if (cnt_q == 8'(RESET_DIR_CYCLES - 1)) begin
          state_d = S_POST_IDLE;
          cnt_d   = 8'd0;
          dir_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_POST_IDLE: begin
        if (cnt_q == 8'(POST_RESET_IDLE - 1)) begin
          state_d = S_RX_TURN;
          dir_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RX_TURN: begin
        state_d      = S_RX_DATA;
        dir_d        = 1'b1;
        oe_d         = 1'b1;
        dout_d       = rxcmd;
        last_rxcmd_d = rxcmd;
      end
      S_RX_DATA: state_d = S_IDLE;
      S_IDLE: begin
        // a line-state change pre-empts whatever the link put on the bus
        if (rxcmd != last_rxcmd_q) begin
          state_d = S_RX_TURN;
          dir_d   = 1'b1;
        end else begin
          case (ulpi.ULPI_DATA_IN[7:6])
            2'b10: begin
              state_d = S_WR_ACKCMD;
              nxt_d   = 1'b1;
              addr_d  = ulpi.ULPI_DATA_IN[5:0];
            end
            2'b11: begin
              state_d = S_RD_ACKCMD;
              nxt_d   = 1'b1;
              addr_d  = ulpi.ULPI_DATA_IN[5:0];
            end
            2'b01: begin
              state_d = S_TX_ACK;
              nxt_d   = 1'b1;
              pid_d   = ulpi.ULPI_DATA_IN[3:0];
              bytes_d = 16'd0;
              cnt_d   = 8'd0;
            end
            default: ;
          endcase
        end
      end
      S_WR_ACKCMD: begin
        state_d = S_WR_ACKDATA;
        nxt_d   = 1'b1;
      end
      S_WR_ACKDATA: begin
        state_d = S_WR_WAITSTP;
        wdata_d = ulpi.ULPI_DATA_IN;
        cnt_d   = 8'd0;
      end
      S_WR_WAITSTP: begin
        if (ulpi.ULPI_STP) begin
          case (addr_q)
            6'h04, 6'h05, 6'h06: func_d    = wr_apply(func_q, addr_q - 6'h04, wdata_q);
            6'h07, 6'h08, 6'h09: ifc_d     = wr_apply(ifc_q, addr_q - 6'h07, wdata_q);
            6'h0A, 6'h0B, 6'h0C: otg_d     = wr_apply(otg_q, addr_q - 6'h0A, wdata_q);
            6'h16, 6'h17, 6'h18: scratch_d = wr_apply(scratch_q, addr_q - 6'h16, wdata_q);
            default: ;
          endcase
          state_d = S_IDLE;
          if (func_d[5]) begin
            func_d[5] = 1'b0;
            state_d   = S_RESET_HOLD;
            cnt_d     = 8'd0;
            dir_d     = 1'b1;
          end
        end else if (cnt_q == 8'(STP_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RD_ACKCMD: begin
        state_d = S_RD_TURN;
        dir_d   = 1'b1;
      end
      S_RD_TURN: begin
        state_d = S_RD_DATA;
        dir_d   = 1'b1;
        oe_d    = 1'b1;
        dout_d  = rd_val;
      end
      S_RD_DATA: state_d = S_IDLE;
      S_TX_ACK: begin
        if (ulpi.ULPI_STP) begin
          state_d   = S_IDLE;
          tx_pid_d  = pid_q;
          tx_cnt_d  = bytes_q;
          tx_done_d = 1'b1;
        end else if (cnt_q == 8'(STP_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          nxt_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          bytes_d = (bytes_q == 16'hFFFF) ? bytes_q : bytes_q + 16'd1;
        end
      end
      default: state_d = S_RESET_HOLD;
    endcase

    if (!ulpi.ULPI_RESETN) begin
      state_d      = S_RESET_HOLD;
      cnt_d        = 8'd0;
      func_d       = 8'h41;
      ifc_d        = 8'h00;
      otg_d        = 8'h06;
      scratch_d    = 8'h00;
      last_rxcmd_d = 8'h00;
      tx_pid_d     = 4'h0;
      tx_cnt_d     = 16'd0;
      dir_d        = 1'b1;
      nxt_d        = 1'b0;
      oe_d         = 1'b0;
      dout_d       = 8'h00;
      tx_done_d    = 1'b0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_RESET_HOLD;
      cnt_q        <= 8'd0;
      addr_q       <= 6'd0;
      wdata_q      <= 8'h00;
      pid_q        <= 4'h0;
      bytes_q      <= 16'd0;
      func_q       <= 8'h41;
      ifc_q        <= 8'h00;
      otg_q        <= 8'h06;
      scratch_q    <= 8'h00;
      last_rxcmd_q <= 8'h00;
      dir_q        <= 1'b1;
      nxt_q        <= 1'b0;
      oe_q         <= 1'b0;
      dout_q       <= 8'h00;
      tx_pid_q     <= 4'h0;
      tx_cnt_q     <= 16'd0;
      tx_done_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pid_q        <= pid_d;
      bytes_q      <= bytes_d;
      func_q       <= func_d;
      ifc_q        <= ifc_d;
      otg_q        <= otg_d;
      scratch_q    <= scratch_d;
      last_rxcmd_q <= last_rxcmd_d;
      dir_q        <= dir_d;
      nxt_q        <= nxt_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      tx_pid_q     <= tx_pid_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_done_q    <= tx_done_d;
      err_q        <= err_d;
    end
  end

  assign ulpi.ULPI_DIR      = dir_q;
  assign ulpi.ULPI_NXT      = nxt_q;
  assign ulpi.ULPI_DATA_OE  = oe_q;
  assign ulpi.ULPI_DATA_OUT = dout_q;
  assign FUNC_CTRL          = func_q;
  assign OTG_CTRL           = otg_q;
  assign TX_PID             = tx_pid_q;
  assign TX_BYTE_CNT        = tx_cnt_q;
  assign TX_DONE            = tx_done_q;
  assign ERR                = err_q;
endmodule

// File: tb/tb_ulpi_phy_emu.sv
// tb/tb_ulpi_phy_emu.sv - scoreboard bench for ulpi_phy_emu
module tb_ulpi_phy_emu;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  LINESTATE;
  logic [1:0]  VBUS;
  logic [7:0]  FUNC_CTRL, OTG_CTRL;
  logic [3:0]  TX_PID;
  logic [15:0] TX_BYTE_CNT;
  logic        TX_DONE, ERR;

  ulpi_phy_emu_if ulpi();

  ulpi_phy_emu dut (
    .CLK(CLK), .RST(RST), .ulpi(ulpi),
    .LINESTATE(LINESTATE), .VBUS(VBUS),
    .FUNC_CTRL(FUNC_CTRL), .OTG_CTRL(OTG_CTRL),
    .TX_PID(TX_PID), .TX_BYTE_CNT(TX_BYTE_CNT),
    .TX_DONE(TX_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int bus_extra = 0;
  int tx_extra = 0;
  int err_pulses = 0;
  logic [7:0]  bus_q[$];
  logic [19:0] tx_q[$];
  logic [7:0]  mon_b;
  logic [19:0] mon_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bus and transmit monitors pop expectations pushed by the stimulus
  always @(negedge CLK) begin
    if (ulpi.ULPI_DATA_OE === 1'b1) begin
      if (bus_q.size() == 0) bus_extra++;
      else begin
        mon_b = bus_q.pop_front();
        check("bus_byte", 32'(ulpi.ULPI_DATA_OUT), 32'(mon_b));
        check("bus_dir", 32'(ulpi.ULPI_DIR), 32'd1);
      end
    end
    if (TX_DONE === 1'b1) begin
      if (tx_q.size() == 0) tx_extra++;
      else begin
        mon_t = tx_q.pop_front();
        check("tx_pid", 32'(TX_PID), 32'(mon_t[19:16]));
        check("tx_cnt", 32'(TX_BYTE_CNT), 32'(mon_t[15:0]));
      end
    end
    if (ERR === 1'b1) err_pulses++;
  end

  task automatic count_dir(input logic lvl, output int n);
    n = 0;
    while (ulpi.ULPI_DIR === lvl && n < 40) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic reset_seq(input string tag);
    int n;
    count_dir(1'b1, n);
    check({tag, "_dir_hold"}, 32'(n), 32'd4);
    count_dir(1'b0, n);
    check({tag, "_post_idle"}, 32'(n), 32'd4);
    check({tag, "_rx_turn_oe"}, 32'(ulpi.ULPI_DATA_OE), 32'd0);
    count_dir(1'b1, n);
    check({tag, "_rx_len"}, 32'(n), 32'd2);
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input bit do_stp);
    ulpi.ULPI_DATA_IN = {2'b10, a};
    @(negedge CLK);
    check("wr_nxt_cmd", 32'(ulpi.ULPI_NXT), 32'd1);
    @(negedge CLK);
    check("wr_nxt_data", 32'(ulpi.ULPI_NXT), 32'd1);
    ulpi.ULPI_DATA_IN = d;
    @(negedge CLK);
    check("wr_nxt_wait", 32'(ulpi.ULPI_NXT), 32'd0);
    ulpi.ULPI_DATA_IN = 8'h00;
    ulpi.ULPI_STP = do_stp;
    if (do_stp) begin
      @(negedge CLK);
      ulpi.ULPI_STP = 1'b0;
    end
  endtask

  task automatic reg_read(input logic [5:0] a, input logic [7:0] exp);
    bus_q.push_back(exp);
    ulpi.ULPI_DATA_IN = {2'b11, a};
    @(negedge CLK);
    check("rd_nxt", 32'(ulpi.ULPI_NXT), 32'd1);
    ulpi.ULPI_DATA_IN = 8'h00;
    @(negedge CLK);
    check("rd_turn", 32'({ulpi.ULPI_DIR, ulpi.ULPI_DATA_OE}), 32'b10);
    @(negedge CLK);
    @(negedge CLK);
    check("rd_release", 32'(ulpi.ULPI_DIR), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal;
  end

  initial begin
    int n;
    LINESTATE         = 2'b01;
    VBUS              = 2'b00;
    ulpi.ULPI_RESETN  = 1'b1;
    ulpi.ULPI_STP     = 1'b0;
    ulpi.ULPI_DATA_IN = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_dir", 32'(ulpi.ULPI_DIR), 32'd1);
    check("rst_oe", 32'(ulpi.ULPI_DATA_OE), 32'd0);
    check("rst_nxt", 32'(ulpi.ULPI_NXT), 32'd0);
    check("rst_dout", 32'(ulpi.ULPI_DATA_OUT), 32'd0);
    check("rst_func", 32'(FUNC_CTRL), 32'h41);
    check("rst_otg", 32'(OTG_CTRL), 32'h06);
    check("rst_txcnt", 32'(TX_BYTE_CNT), 32'd0);
    check("rst_txpid", 32'(TX_PID), 32'd0);

    bus_q.push_back(8'h01);
    RST = 1'b0;
    reset_seq("por");

    reg_write(6'h0A, 8'h66, 1'b1);
    check("otg_write", 32'(OTG_CTRL), 32'h66);
    reg_read(6'h0A, 8'h66);

    bus_q.push_back(8'h01);
    reg_write(6'h04, 8'h60, 1'b1);
    check("func_rst_clear", 32'(FUNC_CTRL), 32'h40);
    reset_seq("frst");
    check("frst_otg_kept", 32'(OTG_CTRL), 32'h66);

    reg_write(6'h05, 8'h04, 1'b1);
    check("func_set", 32'(FUNC_CTRL), 32'h44);
    reg_read(6'h00, 8'h24);
    reg_read(6'h10, 8'h00);
    reg_read(6'h06, 8'h44);

    tx_q.push_back({4'h3, 16'd5});
    ulpi.ULPI_DATA_IN = 8'h43;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      check("tx_nxt", 32'(ulpi.ULPI_NXT), 32'd1);
      ulpi.ULPI_DATA_IN = 8'(i * 17);
    end
    @(negedge CLK);
    ulpi.ULPI_DATA_IN = 8'h00;
    ulpi.ULPI_STP = 1'b1;
    @(negedge CLK);
    ulpi.ULPI_STP = 1'b0;
    check("tx_nxt_end", 32'(ulpi.ULPI_NXT), 32'd0);
    check("tx_done_hi", 32'(TX_DONE), 32'd1);
    @(negedge CLK);
    check("tx_done_lo", 32'(TX_DONE), 32'd0);

    reg_write(6'h0A, 8'h11, 1'b0);
    n = 0;
    while (ERR !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("err_latency", 32'(n), 32'd16);
    check("err_reg_kept", 32'(OTG_CTRL), 32'h66);
    @(negedge CLK);
    check("err_pulse_len", 32'(ERR), 32'd0);

    bus_q.push_back(8'h02);
    LINESTATE = 2'b10;
    ulpi.ULPI_DATA_IN = 8'h84;
    @(negedge CLK);
    check("lc_dir", 32'(ulpi.ULPI_DIR), 32'd1);
    check("lc_nxt", 32'(ulpi.ULPI_NXT), 32'd0);
    ulpi.ULPI_DATA_IN = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    check("lc_release", 32'(ulpi.ULPI_DIR), 32'd0);
    @(negedge CLK);
    check("lc_no_write", 32'(ulpi.ULPI_NXT), 32'd0);
    check("lc_func", 32'(FUNC_CTRL), 32'h44);

    ulpi.ULPI_DATA_IN = 8'h41;
    @(negedge CLK);
    ulpi.ULPI_DATA_IN = 8'h55;
    @(negedge CLK);
    ulpi.ULPI_RESETN = 1'b0;
    ulpi.ULPI_DATA_IN = 8'h00;
    @(negedge CLK);
    check("urst_dir", 32'(ulpi.ULPI_DIR), 32'd1);
    check("urst_nxt", 32'(ulpi.ULPI_NXT), 32'd0);
    check("urst_func", 32'(FUNC_CTRL), 32'h41);
    check("urst_otg", 32'(OTG_CTRL), 32'h06);
    check("urst_txcnt", 32'(TX_BYTE_CNT), 32'd5 & 32'd0);
    bus_q.push_back(8'h02);
    ulpi.ULPI_RESETN = 1'b1;
    reset_seq("urst");

    repeat (2) @(negedge CLK);
    check("bus_left", 32'(bus_q.size()), 32'd0);
    check("bus_extra", 32'(bus_extra), 32'd0);
    check("tx_left", 32'(tx_q.size()), 32'd0);
    check("tx_extra", 32'(tx_extra), 32'd0);
    check("err_count", 32'(err_pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
